// File: rtl/long_div_param.sv
// long_div_param
//
// Computes (num_in * 2^len) mod modulus with a bit-serial restoring
// reduction. The operand is first reduced one bit per cycle, MSB first,
// over WIDTH cycles. The remainder is then doubled and reduced len more
// times. The result appears on ld_out together with a one-cycle md_end
// pulse, WIDTH+len+1 cycles after the start edge.
//
// Optional build macro: LONG_DIV_ZERO_CHECK_EN
//   defined   : a zero modulus is rejected at capture. The block goes
//               straight to DONE, returns ld_out=0 and raises div_err.
//   undefined : div_err is tied low. A zero modulus runs through the
//               normal datapath, giving (num_in << len) truncated.
//
// Ports
//   clk      : clock; all state changes on its rising edge
//   rstn     : synchronous active-low reset
//   md_start : start request, ignored while busy
//   len      : shift count, log2(R)
//   num_in   : operand, any value
//   modulus  : modulus m
//   md_end   : one-cycle completion pulse
//   ld_out   : registered result, held until the next completion or reset
//   busy     : operation in flight (REDUCE, SHIFT, DONE)
//   div_err  : last operation was rejected for m = 0
//
// state  | meaning
// IDLE   | waiting for md_start; operands captured on accept
// REDUCE | WIDTH cycles, one operand bit shifted into the remainder per cycle
// SHIFT  | len cycles, remainder doubled and reduced
// DONE   | result transferred to ld_out, md_end raised for the next cycle

module long_div_param #(
    parameter int WIDTH = 32,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             md_start,
    input  logic [LEN_W-1:0] len,
    input  logic [WIDTH-1:0] num_in,
    input  logic [WIDTH-1:0] modulus,
    output logic             md_end,
    output logic [WIDTH-1:0] ld_out,
    output logic             busy,
    output logic             div_err
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_REDUCE = 2'd1;
    localparam logic [1:0] S_SHIFT  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    // The counter must hold both WIDTH-1 (up to 63) and 2^LEN_W-1.
    localparam int CNT_W = (LEN_W > 7) ? LEN_W : 7;

    logic [1:0]       state;
    logic [WIDTH-1:0] num_q;
    logic [LEN_W-1:0] len_q;
    logic [WIDTH-1:0] mod_q;
    logic [WIDTH-1:0] r_q;
    logic [CNT_W-1:0] cnt_q;

    logic             shift_bit;
    logic [WIDTH:0]   t_val;
    logic [WIDTH:0]   t_sub;
    logic [WIDTH-1:0] r_nxt;

    // t is one bit wider than r. Because r < m, 2r+1 < 2m, so the
    // intermediate value cannot overflow for any m up to 2^WIDTH-1.
    always_comb begin
        shift_bit = 1'b0;
        if (state == S_REDUCE) begin
            shift_bit = num_q[WIDTH-1];
        end
        t_val = {r_q, shift_bit};
        t_sub = t_val - {1'b0, mod_q};
        r_nxt = t_val[WIDTH-1:0];
        if (t_val >= {1'b0, mod_q}) begin
            r_nxt = t_sub[WIDTH-1:0];
        end
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state  <= S_IDLE;
            num_q  <= '0;
            len_q  <= '0;
            mod_q  <= '0;
            r_q    <= '0;
            cnt_q  <= '0;
            md_end <= 1'b0;
            ld_out <= '0;
        end else begin
            md_end <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (md_start) begin
                        num_q <= num_in;
                        len_q <= len;
                        mod_q <= modulus;
                        r_q   <= '0;
                        cnt_q <= CNT_W'(WIDTH - 1);
`ifdef LONG_DIV_ZERO_CHECK_EN
                        if (modulus == '0) begin
                            state <= S_DONE;
                        end else begin
                            state <= S_REDUCE;
                        end
`else
                        state <= S_REDUCE;
`endif
                    end
                end
                S_REDUCE: begin
                    r_q   <= r_nxt;
                    num_q <= {num_q[WIDTH-2:0], 1'b0};
                    if (cnt_q == '0) begin
                        if (len_q == '0) begin
                            state <= S_DONE;
                        end else begin
                            cnt_q <= CNT_W'(len_q) - CNT_W'(1);
                            state <= S_SHIFT;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_SHIFT: begin
                    r_q <= r_nxt;
                    if (cnt_q == '0) begin
                        state <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    md_end <= 1'b1;
                    ld_out <= r_q;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

`ifdef LONG_DIV_ZERO_CHECK_EN
    // Set on a rejected start and held until the next accepted start.
    logic div_err_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            div_err_q <= 1'b0;
        end else if ((state == S_IDLE) && md_start) begin
            div_err_q <= (modulus == '0);
        end
    end

    assign div_err = div_err_q;
`else
    assign div_err = 1'b0;
`endif

endmodule

// File: tb/tb_long_div_param.sv
module tb_long_div_param;

    localparam int WIDTH  = 32;
    localparam int LEN_W  = 8;
    localparam int BUDGET = 400;

    logic             clk;
    logic             rstn;
    logic             md_start;
    logic [LEN_W-1:0] len;
    logic [WIDTH-1:0] num_in;
    logic [WIDTH-1:0] modulus;
    logic             md_end;
    logic [WIDTH-1:0] ld_out;
    logic             busy;
    logic             div_err;

    long_div_param #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .md_start(md_start),
        .len     (len),
        .num_in  (num_in),
        .modulus (modulus),
        .md_end  (md_end),
        .ld_out  (ld_out),
        .busy    (busy),
        .div_err (div_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             err;
        int               lat;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic logic [WIDTH-1:0] model_res(input logic [WIDTH-1:0] n,
                                                   input int l,
                                                   input logic [WIDTH-1:0] m);
        logic [WIDTH:0]   r;
        logic [WIDTH-1:0] sh;
        if (m == '0) begin
`ifdef LONG_DIV_ZERO_CHECK_EN
            return '0;
`else
            sh = n << l;
            return sh;
`endif
        end
        r = {1'b0, n} % {1'b0, m};
        for (int i = 0; i < l; i++) begin
            r = (r << 1) % {1'b0, m};
        end
        return r[WIDTH-1:0];
    endfunction

    function automatic int model_lat(input int l, input logic [WIDTH-1:0] m);
`ifdef LONG_DIV_ZERO_CHECK_EN
        if (m == '0) return 1;
`endif
        return WIDTH + l + 1;
    endfunction

    function automatic logic model_err(input logic [WIDTH-1:0] m);
`ifdef LONG_DIV_ZERO_CHECK_EN
        return (m == '0);
`else
        return (m != m);
`endif
    endfunction

    // Pulses md_start for one edge, then scrambles the operands, which are
    // don't-care after capture. Returns #1 after the start edge.
    task automatic start_op(input logic [WIDTH-1:0] n, input int l,
                            input logic [WIDTH-1:0] m, input bit push);
        exp_t e;
        if (push) begin
            e.res = model_res(n, l, m);
            e.err = model_err(m);
            e.lat = model_lat(l, m);
            exp_q.push_back(e);
        end
        num_in   = n;
        len      = LEN_W'(l);
        modulus  = m;
        md_start = 1'b1;
        @(posedge clk);
        #1;
        md_start = 1'b0;
        num_in   = $urandom;
        len      = LEN_W'($urandom);
        modulus  = $urandom;
    endtask

    task automatic wait_md_end(output int lat, output bit ok);
        lat = 0;
        ok  = 1'b0;
        for (int i = 1; i <= BUDGET; i++) begin
            @(posedge clk);
            #1;
            if (md_end) begin
                lat = i;
                ok  = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rstn     = 1'b0;
        md_start = 1'b0;
        len      = '0;
        num_in   = '0;
        modulus  = '0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (md_end !== 1'b0) begin
            n_fail++; $display("FAIL reset_md_end: got %b want 0", md_end);
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b want 0", busy);
        end
        n_tests++;
        if (div_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_div_err: got %b want 0", div_err);
        end
        n_tests++;
        if (ld_out !== '0) begin
            n_fail++; $display("FAIL reset_ld_out: got %h want 0", ld_out);
        end
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        exp_t e;
        int   lat;
        bit   busy_ok;
        start_op(32'd10, 4, 32'd11, 1'b1);
        e = exp_q.pop_front();
        lat = 0;
        busy_ok = 1'b1;
        for (int i = 1; i <= BUDGET; i++) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            if (md_end) begin
                lat = i;
                break;
            end
        end
        n_tests++;
        if (lat != e.lat) begin
            n_fail++; $display("FAIL basic_latency: got %0d want %0d", lat, e.lat);
        end
        n_tests++;
        if (!busy_ok) begin
            n_fail++; $display("FAIL basic_busy: busy dropped before md_end, want high throughout");
        end
        n_tests++;
        if (ld_out !== e.res) begin
            n_fail++; $display("FAIL basic_result: got %0d want %0d", ld_out, e.res);
        end
        n_tests++;
        if (div_err !== e.err) begin
            n_fail++; $display("FAIL basic_div_err: got %b want %b", div_err, e.err);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_tests++;
            if (md_end !== 1'b0 || ld_out !== e.res || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL basic_hold: md_end=%b ld_out=%0d busy=%b want 0/%0d/0",
                         md_end, ld_out, busy, e.res);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   lat;
        bit   ok;
        start_op(32'd14, 4, 32'd15, 1'b1);
        wait_md_end(lat, ok);
        e = exp_q.pop_front();
        n_tests++;
        if (!ok || lat != e.lat || ld_out !== e.res) begin
            n_fail++;
            $display("FAIL b2b_first: ok=%b lat=%0d res=%0d want lat=%0d res=%0d",
                     ok, lat, ld_out, e.lat, e.res);
        end
        @(posedge clk);
        #1;
        start_op(32'd25, 4, 32'd13, 1'b1);
        wait_md_end(lat, ok);
        e = exp_q.pop_front();
        n_tests++;
        if (!ok || lat != e.lat || ld_out !== e.res) begin
            n_fail++;
            $display("FAIL b2b_second: ok=%b lat=%0d res=%0d want lat=%0d res=%0d",
                     ok, lat, ld_out, e.lat, e.res);
        end
    endtask

    task automatic test_boundary();
        exp_t e;
        int   lat;
        bit   ok;
        start_op(32'hFFFF_FFFF, 0, 32'hFFFF_FFFB, 1'b1);
        wait_md_end(lat, ok);
        e = exp_q.pop_front();
        n_tests++;
        if (!ok || lat != e.lat) begin
            n_fail++; $display("FAIL bound_max_latency: got %0d want %0d", lat, e.lat);
        end
        n_tests++;
        if (ld_out !== e.res) begin
            n_fail++; $display("FAIL bound_max_result: got %h want %h", ld_out, e.res);
        end
        start_op(32'd100, 1, 32'd1, 1'b1);
        wait_md_end(lat, ok);
        e = exp_q.pop_front();
        n_tests++;
        if (!ok || lat != e.lat || ld_out !== e.res) begin
            n_fail++;
            $display("FAIL bound_mod_one: ok=%b lat=%0d res=%0d want lat=%0d res=%0d",
                     ok, lat, ld_out, e.lat, e.res);
        end
    endtask

    task automatic test_zero_mod();
        exp_t e;
        int   lat;
        bit   ok;
        start_op(32'd10, 0, 32'd0, 1'b1);
        wait_md_end(lat, ok);
        e = exp_q.pop_front();
        n_tests++;
        if (!ok || lat != e.lat) begin
            n_fail++; $display("FAIL zero_latency: got %0d want %0d", lat, e.lat);
        end
        n_tests++;
        if (ld_out !== e.res) begin
            n_fail++; $display("FAIL zero_result: got %0d want %0d", ld_out, e.res);
        end
        n_tests++;
        if (div_err !== e.err) begin
            n_fail++; $display("FAIL zero_div_err: got %b want %b", div_err, e.err);
        end
        start_op(32'd9, 2, 32'd7, 1'b1);
        wait_md_end(lat, ok);
        e = exp_q.pop_front();
        n_tests++;
        if (!ok || div_err !== e.err || ld_out !== e.res) begin
            n_fail++;
            $display("FAIL zero_recover: ok=%b err=%b res=%0d want err=%b res=%0d",
                     ok, div_err, ld_out, e.err, e.res);
        end
    endtask

    task automatic test_ignore_start();
        exp_t e;
        int   lat;
        int   n_end;
        start_op(32'd7, 2, 32'd9, 1'b1);
        e = exp_q.pop_front();
        lat = 0;
        n_end = 0;
        for (int i = 1; i <= 80; i++) begin
            @(posedge clk);
            #1;
            md_start = 1'b0;
            if (md_end) begin
                n_end++;
                if (n_end == 1) begin
                    lat = i;
                    n_tests++;
                    if (ld_out !== e.res) begin
                        n_fail++; $display("FAIL ignore_result: got %0d want %0d", ld_out, e.res);
                    end
                end
            end
            if (i == 5) begin
                num_in   = 32'd50;
                len      = LEN_W'(0);
                modulus  = 32'd7;
                md_start = 1'b1;
            end
        end
        n_tests++;
        if (n_end != 1 || lat != e.lat) begin
            n_fail++;
            $display("FAIL ignore_single_end: pulses=%0d lat=%0d want 1 at %0d", n_end, lat, e.lat);
        end
    endtask

    task automatic test_reset_abort();
        exp_t e;
        int   lat;
        bit   ok;
        int   n_end;
        start_op(32'd123, 5, 32'd97, 1'b0);
        repeat (8) @(posedge clk);
        #1;
        rstn     = 1'b0;
        md_start = 1'b1;
        @(posedge clk);
        #1;
        md_start = 1'b0;
        n_tests++;
        if (md_end !== 1'b0 || busy !== 1'b0 || div_err !== 1'b0 || ld_out !== '0) begin
            n_fail++;
            $display("FAIL abort_outputs: md_end=%b busy=%b err=%b ld_out=%0d want all 0",
                     md_end, busy, div_err, ld_out);
        end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        n_end = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (md_end) n_end++;
        end
        n_tests++;
        if (n_end != 0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL abort_no_end: pulses=%0d busy=%b want 0/0", n_end, busy);
        end
        start_op(32'd20, 3, 32'd5, 1'b1);
        wait_md_end(lat, ok);
        e = exp_q.pop_front();
        n_tests++;
        if (!ok || lat != e.lat || ld_out !== e.res) begin
            n_fail++;
            $display("FAIL abort_next_op: ok=%b lat=%0d res=%0d want lat=%0d res=%0d",
                     ok, lat, ld_out, e.lat, e.res);
        end
    endtask

    task automatic test_random();
        exp_t             e;
        int               lat;
        bit               ok;
        logic [WIDTH-1:0] n;
        logic [WIDTH-1:0] m;
        int               l;
        for (int k = 0; k < 8; k++) begin
            n = $urandom;
            m = (k % 2 == 0) ? 32'($urandom) : 32'($urandom_range(1, 1000));
            l = $urandom_range(0, 40);
            start_op(n, l, m, 1'b1);
            wait_md_end(lat, ok);
            e = exp_q.pop_front();
            n_tests++;
            if (!ok || lat != e.lat || ld_out !== e.res || div_err !== e.err) begin
                n_fail++;
                $display("FAIL random_%0d: n=%h l=%0d m=%h got res=%h lat=%0d want res=%h lat=%0d",
                         k, n, l, m, ld_out, lat, e.res, e.lat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_boundary();
        test_zero_mod();
        test_ignore_start();
        test_reset_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
